// File: rtl/spi_read_module_pkg.sv
// Shared constants for the SPI read path: FSM encoding, default timing and
// the bit positions of CS/SCLK inside the two-bit SPI_Out bus.
package spi_pkg;

  localparam int DEFAULT_HALF_CNT = 24;

  localparam int CS_BIT   = 1;
  localparam int SCLK_BIT = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/spi_read_module_sync_2ff.sv
// Two-flop synchronizer that brings the slave's MISO line into the CLK domain.
module sync_2ff (
  input  logic CLK,
  input  logic RSTn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_read_module.sv
// Mode-3 SPI master receiver: drives CS/SCLK and shifts in a burst of bytes
// from MISO, MSB first, under the level Start_Sig / pulse Done_Sig handshake.
module spi_read_module
  import spi_pkg::*;
#(
  parameter int HALF_CNT = DEFAULT_HALF_CNT,
  parameter int LEN_W    = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start_Sig,
  input  logic [LEN_W-1:0] Read_Len,
  input  logic             SPI_In,
  output logic [7:0]       Rd_Data,
  output logic             Rd_Valid,
  output logic             Done_Sig,
  output logic             Busy,
  output logic [1:0]       SPI_Out
);

  localparam int CNT_W = (HALF_CNT < 1) ? 1 : $clog2(HALF_CNT + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] half_cnt;
  logic [2:0]       bit_cnt;
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] len_q;
  logic [6:0]       shift;
  logic             byte_done;
  logic             cs_q;
  logic             sclk_q;
  logic             miso_s;
  logic             half_wrap;
  logic             timed;
  logic             abort;

  sync_2ff u_miso_sync (
    .CLK  (CLK),
    .RSTn (RSTn),
    .d    (SPI_In),
    .q    (miso_s)
  );

  assign half_wrap = (half_cnt == CNT_W'(HALF_CNT));
  assign timed     = (state == ST_SETUP) || (state == ST_LOW) ||
                     (state == ST_HIGH)  || (state == ST_HOLD);
  // The final HOLD edge completes the burst even if Start_Sig drops on it.
  assign abort     = timed && !Start_Sig && !((state == ST_HOLD) && half_wrap);

  assign SPI_Out[CS_BIT]   = cs_q;
  assign SPI_Out[SCLK_BIT] = sclk_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      len_q     <= '0;
      shift     <= '0;
      byte_done <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
      Rd_Data   <= '0;
      Rd_Valid  <= 1'b0;
      Done_Sig  <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Rd_Valid <= 1'b0;
      Done_Sig <= 1'b0;
      if (timed && !half_wrap)
        half_cnt <= half_cnt + 1'b1;
      else
        half_cnt <= '0;

      if (abort) begin
        state     <= ST_IDLE;
        cs_q      <= 1'b1;
        sclk_q    <= 1'b1;
        Busy      <= 1'b0;
        half_cnt  <= '0;
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        byte_done <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            Busy <= 1'b0;
            if (Start_Sig) begin
              len_q     <= (Read_Len == '0) ? LEN_W'(1) : Read_Len;
              cs_q      <= 1'b0;
              Busy      <= 1'b1;
              bit_cnt   <= '0;
              byte_cnt  <= '0;
              byte_done <= 1'b0;
              state     <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (half_wrap) begin
              sclk_q <= 1'b0;
              state  <= ST_LOW;
            end
          end
          ST_LOW: begin
            if (half_wrap) begin
              sclk_q <= 1'b1;
              state  <= ST_HIGH;
              if (bit_cnt == 3'd7) begin
                Rd_Data   <= {shift, miso_s};
                Rd_Valid  <= 1'b1;
                bit_cnt   <= '0;
                byte_cnt  <= byte_cnt + 1'b1;
                byte_done <= 1'b1;
              end else begin
                shift   <= {shift[5:0], miso_s};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_HIGH: begin
            if (half_wrap) begin
              byte_done <= 1'b0;
              if (byte_done && (byte_cnt == len_q)) begin
                state <= ST_HOLD;
              end else begin
                sclk_q <= 1'b0;
                state  <= ST_LOW;
              end
            end
          end
          ST_HOLD: begin
            if (half_wrap) begin
              cs_q     <= 1'b1;
              Done_Sig <= 1'b1;
              state    <= Start_Sig ? ST_DONE : ST_IDLE;
            end
          end
          ST_DONE: begin
            Busy <= 1'b0;
            if (!Start_Sig)
              state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_read_module.sv
// Self-checking bench for spi_read_module with a mode-3 SPI slave model
// that shifts preset bytes out on SCLK falling edges.
module tb_spi_read_module;

  localparam int H = 25;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Start_Sig;
  logic [3:0] Read_Len;
  logic       SPI_In = 1'b0;
  logic [7:0] Rd_Data;
  logic       Rd_Valid;
  logic       Done_Sig;
  logic       Busy;
  logic [1:0] SPI_Out;

  logic cs;
  logic sclk;
  assign cs   = SPI_Out[1];
  assign sclk = SPI_Out[0];

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int done_total = 0;
  int expected_done = 0;

  typedef struct {
    logic [3:0] len;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         nbytes;
    int         done_at;
    int         hold;
  } vec_t;

  vec_t vecs[4];

  spi_read_module #(.HALF_CNT(24), .LEN_W(4)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Start_Sig (Start_Sig),
    .Read_Len  (Read_Len),
    .SPI_In    (SPI_In),
    .Rd_Data   (Rd_Data),
    .Rd_Valid  (Rd_Valid),
    .Done_Sig  (Done_Sig),
    .Busy      (Busy),
    .SPI_Out   (SPI_Out)
  );

  always #5 CLK = ~CLK;

  // Slave: reload on CS fall, present the next bit on every SCLK fall.
  logic [7:0] slave_bytes [16];
  logic [7:0] slave_sr = 8'h00;
  int         slave_idx = 0;
  int         slave_bit = 0;
  logic       p_cs = 1'b1;
  logic       p_sclk = 1'b1;

  always @(cs or sclk) begin
    if (p_cs === 1'b1 && cs === 1'b0) begin
      slave_idx = 0;
      slave_bit = 0;
      slave_sr  = slave_bytes[0];
    end else if (p_sclk === 1'b1 && sclk === 1'b0 && cs === 1'b0) begin
      SPI_In    = slave_sr[7];
      slave_sr  = {slave_sr[6:0], 1'b0};
      slave_bit = slave_bit + 1;
      if (slave_bit == 8) begin
        slave_bit = 0;
        if (slave_idx < 15) slave_idx = slave_idx + 1;
        slave_sr = slave_bytes[slave_idx];
      end
    end
    p_cs   = cs;
    p_sclk = sclk;
  end

  // Protocol rules: single-cycle pulses, SCLK moves only while CS is low.
  logic m_valid = 1'b0;
  logic m_done = 1'b0;
  logic m_cs = 1'b1;
  logic m_sclk = 1'b1;

  always @(negedge CLK) begin
    if (Rd_Valid && m_valid) viol++;
    if (Done_Sig && m_done) viol++;
    if ((sclk !== m_sclk) && (m_cs !== 1'b0)) viol++;
    if (Done_Sig === 1'b1) done_total++;
    m_valid = Rd_Valid;
    m_done  = Done_Sig;
    m_cs    = cs;
    m_sclk  = sclk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one burst from a table record; called right after a CLK negedge.
  task automatic applyStimulus(input vec_t v);
    logic [7:0] exp_b [3];
    int e, vcount, rises, cslow, done_at, hold_cs, hold_done;
    logic busy_at_done, prev_sclk, seen;
    exp_b[0] = v.b0;
    exp_b[1] = v.b1;
    exp_b[2] = v.b2;
    for (int i = 0; i < 3; i++) slave_bytes[i] = exp_b[i];
    e = -1; vcount = 0; rises = 0; cslow = 0; done_at = -1;
    busy_at_done = 1'b0; prev_sclk = 1'b1; seen = 1'b0;
    Read_Len  = v.len;
    Start_Sig = 1'b1;
    while (!seen && e < v.done_at + 100) begin
      @(negedge CLK);
      e++;
      if (e == 5) Read_Len = ~v.len;
      if (Rd_Valid) begin
        if (vcount < 3) begin
          checkOutput($sformatf("rd_data_byte%0d", vcount), int'(Rd_Data), int'(exp_b[vcount]));
          checkOutput($sformatf("rd_valid_time%0d", vcount), e, 16 * H * (vcount + 1));
        end
        vcount++;
      end
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (!cs) cslow++;
      if (Done_Sig) begin
        seen = 1'b1;
        done_at = e;
        busy_at_done = Busy;
      end
    end
    checkOutput("done_latency", done_at, v.done_at);
    checkOutput("rd_valid_count", vcount, v.nbytes);
    checkOutput("sclk_rises", rises, 8 * v.nbytes);
    checkOutput("cs_low_cycles", cslow, v.done_at);
    checkOutput("busy_at_done", int'(busy_at_done), 1);
    checkOutput("rd_data_final", int'(Rd_Data), int'(exp_b[v.nbytes - 1]));
    expected_done++;
    hold_cs = 0; hold_done = 0;
    repeat (v.hold) begin
      @(negedge CLK);
      if (!cs) hold_cs++;
      if (Done_Sig) hold_done++;
    end
    if (v.hold > 0) begin
      checkOutput("held_start_no_cs", hold_cs, 0);
      checkOutput("held_start_no_done", hold_done, 0);
      checkOutput("held_start_busy", int'(Busy), 0);
    end
    Start_Sig = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("idle_busy", int'(Busy), 0);
    checkOutput("idle_spi_out", int'(SPI_Out), 3);
  endtask

  initial begin
    int rises, n, cnt_v, cnt_d;
    logic prev_sclk;

    vecs[0] = '{len: 4'd1, b0: 8'hA5, b1: 8'h00, b2: 8'h00, nbytes: 1, done_at: 450,  hold: 1000};
    vecs[1] = '{len: 4'd3, b0: 8'h3C, b1: 8'hFF, b2: 8'h00, nbytes: 3, done_at: 1250, hold: 0};
    vecs[2] = '{len: 4'd0, b0: 8'h5A, b1: 8'h00, b2: 8'h00, nbytes: 1, done_at: 450,  hold: 0};
    vecs[3] = '{len: 4'd2, b0: 8'h81, b1: 8'h7E, b2: 8'h00, nbytes: 2, done_at: 850,  hold: 0};
    for (int i = 0; i < 16; i++) slave_bytes[i] = 8'h00;

    RSTn = 1'b0; Start_Sig = 1'b0; Read_Len = 4'd0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_spi_out", int'(SPI_Out), 3);
    checkOutput("reset_rd_data", int'(Rd_Data), 0);
    checkOutput("reset_rd_valid", int'(Rd_Valid), 0);
    checkOutput("reset_done", int'(Done_Sig), 0);
    checkOutput("reset_busy", int'(Busy), 0);
    RSTn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Abort after five SCLK rises of the first byte.
    slave_bytes[0] = 8'hC3;
    Read_Len = 4'd1; Start_Sig = 1'b1;
    rises = 0; n = 0; prev_sclk = 1'b1;
    while (rises < 5 && n < 3000) begin
      @(negedge CLK);
      n++;
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
    end
    checkOutput("abort_reached_5_rises", rises, 5);
    Start_Sig = 1'b0;
    @(negedge CLK);
    checkOutput("abort_spi_out", int'(SPI_Out), 3);
    checkOutput("abort_busy", int'(Busy), 0);
    cnt_v = 0; cnt_d = 0;
    repeat (600) begin
      @(negedge CLK);
      if (Rd_Valid) cnt_v++;
      if (Done_Sig) cnt_d++;
    end
    checkOutput("abort_no_valid", cnt_v, 0);
    checkOutput("abort_no_done", cnt_d, 0);
    checkOutput("abort_rd_data_kept", int'(Rd_Data), 8'h7E);

    // Start_Sig drops on the very edge that raises Done_Sig.
    slave_bytes[0] = 8'h42;
    Read_Len = 4'd1; Start_Sig = 1'b1;
    repeat (450) @(negedge CLK);
    Start_Sig = 1'b0;
    @(negedge CLK);
    checkOutput("late_drop_done", int'(Done_Sig), 1);
    checkOutput("late_drop_rd_data", int'(Rd_Data), 8'h42);
    expected_done++;
    @(negedge CLK);
    checkOutput("late_drop_done_cleared", int'(Done_Sig), 0);
    checkOutput("late_drop_busy", int'(Busy), 0);
    checkOutput("late_drop_spi_out", int'(SPI_Out), 3);

    // Asynchronous reset in the middle of a byte.
    slave_bytes[0] = 8'h99;
    Read_Len = 4'd1; Start_Sig = 1'b1;
    rises = 0; n = 0; prev_sclk = 1'b1;
    while (rises < 3 && n < 3000) begin
      @(negedge CLK);
      n++;
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
    end
    checkOutput("reset_mid_reached_3_rises", rises, 3);
    #3 RSTn = 1'b0;
    #1;
    checkOutput("async_reset_spi_out", int'(SPI_Out), 3);
    checkOutput("async_reset_busy", int'(Busy), 0);
    checkOutput("async_reset_rd_data", int'(Rd_Data), 0);
    Start_Sig = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    applyStimulus('{len: 4'd1, b0: 8'h66, b1: 8'h00, b2: 8'h00, nbytes: 1, done_at: 450, hold: 0});

    repeat (5) @(negedge CLK);
    checkOutput("protocol_rule_violations", viol, 0);
    checkOutput("done_count", done_total, expected_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
